// File: rtl/estacionamento_pkg.sv
// Shared types and default constants for the parking-lot controllers
// (gate arbiter, password FSM and friends).
package estacionamento_pkg;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ABERTA   = 2'd1,
        PASSANDO = 2'd2,
        FECHANDO = 2'd3
    } estado_t;

    typedef enum logic {
        DIR_ENTRADA = 1'b0,
        DIR_SAIDA   = 1'b1
    } direcao_t;

    localparam int VAGAS_PADRAO       = 16;
    localparam int TICKS_POR_S_PADRAO = 760;
    localparam int TIMEOUT_S_PADRAO   = 20;
    localparam int GUARDA_PADRAO      = 76;

    function automatic direcao_t outra_direcao(input direcao_t d);
        return (d == DIR_ENTRADA) ? DIR_SAIDA : DIR_ENTRADA;
    endfunction

endpackage

// File: rtl/temporizador_segundos.sv
// Seconds timer: a prescaler of TICKS_POR_S cycles feeding a seconds counter.
// expirado_o is raised during the cycle that completes TIMEOUT_S seconds of
// enabled counting, so the caller can act on that very edge; it then holds
// until cleared.
module temporizador_segundos
    import estacionamento_pkg::*;
#(
    parameter int TICKS_POR_S = TICKS_POR_S_PADRAO,
    parameter int TIMEOUT_S   = TIMEOUT_S_PADRAO
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic limpar_i,
    input  logic habilitar_i,
    output logic expirado_o
);
    localparam int PRE_W = (TICKS_POR_S > 1) ? $clog2(TICKS_POR_S) : 1;
    localparam int SEG_W = $clog2(TIMEOUT_S + 1);

    logic [PRE_W-1:0] presc_q, presc_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic             fim_segundo;
    logic             atingido;

    // Next count: prescaler wraps every second, seconds stop at the limit.
    always_comb begin
        fim_segundo = (presc_q == PRE_W'(TICKS_POR_S - 1));
        atingido    = (seg_q == SEG_W'(TIMEOUT_S));
        presc_d     = presc_q;
        seg_d       = seg_q;
        if (habilitar_i && !atingido) begin
            if (fim_segundo) begin
                presc_d = '0;
                seg_d   = seg_q + 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
        expirado_o = atingido ||
                     (habilitar_i && fim_segundo && (seg_q == SEG_W'(TIMEOUT_S - 1)));
    end

    // Counter registers, cleared by reset or by the owner.
    always_ff @(posedge clk_i) begin
        if (rst_i || limpar_i) begin
            presc_q <= '0;
            seg_q   <= '0;
        end else begin
            presc_q <= presc_d;
            seg_q   <= seg_d;
        end
    end

endmodule

// File: rtl/arbitro_cancela.sv
// Gate arbiter: shares the parking gate between entry and exit requests,
// sequences each gate cycle (open, wait vehicle, passage, close, guard) and
// keeps the occupancy count with CHEIO/VAZIO flags.
// Optional macro PRIORIDADE_SAIDA_EN: exit always wins a tie; otherwise ties
// are broken round-robin (side not served last wins, entry first after reset).
module arbitro_cancela
    import estacionamento_pkg::*;
#(
    parameter int VAGAS       = VAGAS_PADRAO,
    parameter int TICKS_POR_S = TICKS_POR_S_PADRAO,
    parameter int TIMEOUT_S   = TIMEOUT_S_PADRAO,
    parameter int GUARDA      = GUARDA_PADRAO
) (
    input  logic                         CLK_760HZ,
    input  logic                         RESET,
    input  logic                         PEDIDO_ENTRADA,
    input  logic                         PEDIDO_SAIDA,
    input  logic                         SENSOR_EXTERNO,
    input  logic                         SENSOR_INTERNO,
    output logic                         CANCELA_ABERTA,
    output logic                         CONCEDIDO_ENTRADA,
    output logic                         CONCEDIDO_SAIDA,
    output logic                         NEGADO,
    output logic                         ERRO_TEMPO,
    output logic                         CHEIO,
    output logic                         VAZIO,
    output logic [$clog2(VAGAS+1)-1:0]   OCUPACAO
);
    localparam int OCUP_W   = $clog2(VAGAS + 1);
    localparam int GUARDA_W = (GUARDA > 1) ? $clog2(GUARDA) : 1;

    estado_t             estado_q;
    direcao_t            dir_q;
    direcao_t            prox_q;
    logic                pend_ent_q, pend_ent_d;
    logic                pend_sai_q, pend_sai_d;
    logic [OCUP_W-1:0]   ocup_q, ocup_d;
    logic                cheio_q, vazio_q;
    logic                cancela_q, conc_ent_q, conc_sai_q;
    logic                negado_q, negado_d, erro_q;
    logic [GUARDA_W-1:0] guarda_q;

    logic     sensor_ativo;
    logic     em_ocioso;
    logic     ent_valida, sai_valida;
    logic     descarta_ent, descarta_sai;
    logic     concede;
    direcao_t dir_conc;
    logic     passagem;
    logic     expirado;

    // The timeout only counts while the gate waits open for a vehicle.
    temporizador_segundos #(
        .TICKS_POR_S (TICKS_POR_S),
        .TIMEOUT_S   (TIMEOUT_S)
    ) u_temporizador (
        .clk_i       (CLK_760HZ),
        .rst_i       (RESET),
        .limpar_i    (estado_q != ABERTA),
        .habilitar_i (estado_q == ABERTA),
        .expirado_o  (expirado)
    );

    // Request bookkeeping, grant choice and next occupancy.
    always_comb begin
        sensor_ativo = (dir_q == DIR_ENTRADA) ? SENSOR_INTERNO : SENSOR_EXTERNO;
        em_ocioso    = (estado_q == OCIOSO);
        ent_valida   = pend_ent_q && !cheio_q;
        sai_valida   = pend_sai_q && !vazio_q;
        // A pending request that became impossible is dropped at grant time.
        descarta_ent = em_ocioso && pend_ent_q && cheio_q;
        descarta_sai = em_ocioso && pend_sai_q && vazio_q;
        concede      = em_ocioso && (ent_valida || sai_valida);
`ifdef PRIORIDADE_SAIDA_EN
        dir_conc = sai_valida ? DIR_SAIDA : DIR_ENTRADA;
`else
        if (ent_valida && sai_valida) begin
            dir_conc = prox_q;
        end else begin
            dir_conc = sai_valida ? DIR_SAIDA : DIR_ENTRADA;
        end
`endif
        // A fresh pulse wins over the clear of a grant on the same edge.
        pend_ent_d = (PEDIDO_ENTRADA && !cheio_q) ||
                     (pend_ent_q && !(descarta_ent || (concede && dir_conc == DIR_ENTRADA)));
        pend_sai_d = (PEDIDO_SAIDA && !vazio_q) ||
                     (pend_sai_q && !(descarta_sai || (concede && dir_conc == DIR_SAIDA)));
        negado_d   = (PEDIDO_ENTRADA && cheio_q) || (PEDIDO_SAIDA && vazio_q) ||
                     descarta_ent || descarta_sai;

        passagem = (estado_q == PASSANDO) && !sensor_ativo;
        ocup_d   = ocup_q;
        if (passagem) begin
            if (dir_q == DIR_ENTRADA) begin
                if (ocup_q != OCUP_W'(VAGAS)) ocup_d = ocup_q + 1'b1;
            end else begin
                if (ocup_q != '0) ocup_d = ocup_q - 1'b1;
            end
        end
    end

    // Gate FSM with registered outputs, pending latches and occupancy.
    always_ff @(posedge CLK_760HZ) begin
        if (RESET) begin
            estado_q   <= OCIOSO;
            dir_q      <= DIR_ENTRADA;
            prox_q     <= DIR_ENTRADA;
            pend_ent_q <= 1'b0;
            pend_sai_q <= 1'b0;
            ocup_q     <= '0;
            cheio_q    <= 1'b0;
            vazio_q    <= 1'b1;
            cancela_q  <= 1'b0;
            conc_ent_q <= 1'b0;
            conc_sai_q <= 1'b0;
            negado_q   <= 1'b0;
            erro_q     <= 1'b0;
            guarda_q   <= '0;
        end else begin
            pend_ent_q <= pend_ent_d;
            pend_sai_q <= pend_sai_d;
            negado_q   <= negado_d;
            erro_q     <= 1'b0;
            ocup_q     <= ocup_d;
            cheio_q    <= (ocup_d == OCUP_W'(VAGAS));
            vazio_q    <= (ocup_d == '0);
            case (estado_q)
                OCIOSO: begin
                    if (concede) begin
                        estado_q   <= ABERTA;
                        dir_q      <= dir_conc;
                        prox_q     <= outra_direcao(dir_conc);
                        cancela_q  <= 1'b1;
                        conc_ent_q <= (dir_conc == DIR_ENTRADA);
                        conc_sai_q <= (dir_conc == DIR_SAIDA);
                    end
                end
                ABERTA: begin
                    // A vehicle on the loop always beats the timeout.
                    if (sensor_ativo) begin
                        estado_q <= PASSANDO;
                    end else if (expirado) begin
                        estado_q   <= FECHANDO;
                        erro_q     <= 1'b1;
                        cancela_q  <= 1'b0;
                        conc_ent_q <= 1'b0;
                        conc_sai_q <= 1'b0;
                        guarda_q   <= '0;
                    end
                end
                PASSANDO: begin
                    if (passagem) begin
                        estado_q   <= FECHANDO;
                        cancela_q  <= 1'b0;
                        conc_ent_q <= 1'b0;
                        conc_sai_q <= 1'b0;
                        guarda_q   <= '0;
                    end
                end
                FECHANDO: begin
                    if (guarda_q == GUARDA_W'(GUARDA - 1)) begin
                        estado_q <= OCIOSO;
                    end else begin
                        guarda_q <= guarda_q + 1'b1;
                    end
                end
                default: estado_q <= OCIOSO;
            endcase
        end
    end

    assign CANCELA_ABERTA    = cancela_q;
    assign CONCEDIDO_ENTRADA = conc_ent_q;
    assign CONCEDIDO_SAIDA   = conc_sai_q;
    assign NEGADO            = negado_q;
    assign ERRO_TEMPO        = erro_q;
    assign CHEIO             = cheio_q;
    assign VAZIO             = vazio_q;
    assign OCUPACAO          = ocup_q;

endmodule

// File: tb/tb_arbitro_cancela.sv
// Bench for arbitro_cancela: hand-derived vector table, directed corner
// sequences and randomized traffic against a deadline-based reference model.
module tb_arbitro_cancela;
    localparam int VAGAS  = 16;
    localparam int TICKS  = 760;
    localparam int TOUT   = 20;
    localparam int GUARDA = 76;
    localparam int N_TOUT = TICKS * TOUT;

    logic clk = 1'b0;
    logic rst, pe, ps, se, si;
    logic cancela, ce, cs, neg, erro, cheio, vazio;
    logic [4:0] ocup;

    always #5 clk = ~clk;

    arbitro_cancela #(
        .VAGAS(VAGAS), .TICKS_POR_S(TICKS), .TIMEOUT_S(TOUT), .GUARDA(GUARDA)
    ) dut (
        .CLK_760HZ         (clk),
        .RESET             (rst),
        .PEDIDO_ENTRADA    (pe),
        .PEDIDO_SAIDA      (ps),
        .SENSOR_EXTERNO    (se),
        .SENSOR_INTERNO    (si),
        .CANCELA_ABERTA    (cancela),
        .CONCEDIDO_ENTRADA (ce),
        .CONCEDIDO_SAIDA   (cs),
        .NEGADO            (neg),
        .ERRO_TEMPO        (erro),
        .CHEIO             (cheio),
        .VAZIO             (vazio),
        .OCUPACAO          (ocup)
    );

    int vetores = 0;
    int erros   = 0;

    // Reference model: occupancy as an integer, served side (-1 none,
    // 0 entry, 1 exit), absolute-cycle deadlines for timeout and guard end.
    longint ciclo = 0;
    int     m_ocup, m_lado, m_prox;
    bit     m_pe, m_ps, m_veic, m_neg, m_erro;
    longint m_prazo, m_livre;

    function automatic void modelo_reset();
        m_ocup = 0; m_lado = -1; m_prox = 0;
        m_pe = 0; m_ps = 0; m_veic = 0; m_neg = 0; m_erro = 0;
        m_prazo = 0; m_livre = 0;
    endfunction

    function automatic void modelo_passo();
        bit cheio_m, vazio_m, s;
        int esc;
        ciclo++;
        if (rst) begin
            modelo_reset();
            return;
        end
        cheio_m = (m_ocup == VAGAS);
        vazio_m = (m_ocup == 0);
        m_neg = 0;
        m_erro = 0;
        if (m_lado < 0) begin
            if (ciclo >= m_livre) begin
                if (m_pe && cheio_m) begin m_pe = 0; m_neg = 1; end
                if (m_ps && vazio_m) begin m_ps = 0; m_neg = 1; end
                if (m_pe || m_ps) begin
`ifdef PRIORIDADE_SAIDA_EN
                    esc = m_ps ? 1 : 0;
`else
                    if (m_pe && m_ps) esc = m_prox;
                    else esc = m_ps ? 1 : 0;
`endif
                    m_lado = esc;
                    if (esc == 0) m_pe = 0; else m_ps = 0;
                    m_prox = 1 - esc;
                    m_veic = 0;
                    m_prazo = ciclo + N_TOUT;
                end
            end
        end else begin
            s = (m_lado == 0) ? si : se;
            if (!m_veic) begin
                if (s) m_veic = 1;
                else if (ciclo == m_prazo) begin
                    m_erro = 1; m_lado = -1; m_livre = ciclo + GUARDA + 1;
                end
            end else if (!s) begin
                if (m_lado == 0) m_ocup = (m_ocup < VAGAS) ? m_ocup + 1 : VAGAS;
                else             m_ocup = (m_ocup > 0) ? m_ocup - 1 : 0;
                m_lado = -1;
                m_livre = ciclo + GUARDA + 1;
            end
        end
        if (pe) begin if (cheio_m) m_neg = 1; else m_pe = 1; end
        if (ps) begin if (vazio_m) m_neg = 1; else m_ps = 1; end
    endfunction

    function automatic logic [11:0] saidas_modelo();
        logic [4:0] o;
        o = 5'(m_ocup);
        return {m_lado >= 0, m_lado == 0, m_lado == 1, m_neg, m_erro,
                m_ocup == VAGAS, m_ocup == 0, o};
    endfunction

    task automatic comparar(input string nome, input logic [31:0] obtido, input logic [31:0] esperado);
        vetores++;
        if (obtido !== esperado) begin
            erros++;
            $display("FAIL %s @ciclo %0d: obtido=%0h esperado=%0h", nome, ciclo, obtido, esperado);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelo_passo();
        #1;
        comparar("modelo", {cancela, ce, cs, neg, erro, cheio, vazio, ocup}, saidas_modelo());
    endtask

    task automatic espera_cancela(input int lim);
        int n;
        n = 0;
        while (cancela !== 1'b1 && n < lim) begin tick(); n++; end
        comparar("espera_cancela", cancela, 1);
    endtask

    task automatic servir(input bit entrada);
        espera_cancela(200);
        if (entrada) si = 1; else se = 1;
        repeat (3) tick();
        si = 0; se = 0;
        tick();
        repeat (GUARDA + 4) tick();
    endtask

    task automatic ciclo_gate(input bit entrada);
        if (entrada) pe = 1; else ps = 1;
        tick();
        pe = 0; ps = 0;
        servir(entrada);
    endtask

    typedef struct {
        int rep;
        bit pe, ps, se, si;
        bit can, ce, cs, neg;
        int ocup;
    } vetor_t;

    vetor_t tab[15];

    initial begin
        bit abriu, viu_erro, fechou;
        int n;

        // rep, pe ps se si, cancela ce cs negado, ocupacao
        tab[0]  = '{1,  1,0,0,0, 0,0,0,0, 0};
        tab[1]  = '{1,  0,0,0,0, 1,1,0,0, 0};
        tab[2]  = '{3,  0,0,1,0, 1,1,0,0, 0};
        tab[3]  = '{10, 0,0,0,1, 1,1,0,0, 0};
        tab[4]  = '{1,  0,0,1,0, 0,0,0,0, 1};
        tab[5]  = '{1,  1,0,0,0, 0,0,0,0, 1};
        tab[6]  = '{75, 0,0,0,0, 0,0,0,0, 1};
        tab[7]  = '{1,  0,0,0,0, 1,1,0,0, 1};
        tab[8]  = '{2,  0,0,0,1, 1,1,0,0, 1};
        tab[9]  = '{1,  0,0,0,0, 0,0,0,0, 2};
        tab[10] = '{1,  0,1,0,0, 0,0,0,0, 2};
        tab[11] = '{75, 0,0,0,0, 0,0,0,0, 2};
        tab[12] = '{1,  0,0,0,0, 1,0,1,0, 2};
        tab[13] = '{1,  0,0,1,0, 1,0,1,0, 2};
        tab[14] = '{1,  0,0,0,0, 0,0,0,0, 1};

        modelo_reset();
        rst = 1; pe = 0; ps = 0; se = 0; si = 0;
        tick(); tick();
        comparar("reset", {cancela, ce, cs, neg, erro, cheio, vazio, ocup}, 12'b0000001_00000);
        rst = 0;
        tick();

        // Table: entry cycle with guard timing, then an exit cycle.
        for (int i = 0; i < 15; i++) begin
            for (int r = 0; r < tab[i].rep; r++) begin
                pe = tab[i].pe; ps = tab[i].ps; se = tab[i].se; si = tab[i].si;
                tick();
                comparar($sformatf("tab%0d", i), {cancela, ce, cs, neg, ocup},
                         {tab[i].can, tab[i].ce, tab[i].cs, tab[i].neg, 5'(tab[i].ocup)});
            end
        end
        pe = 0; ps = 0; se = 0; si = 0;
        repeat (GUARDA + 4) tick();

        // Fill the lot, then an entry request must be refused.
        repeat (15) ciclo_gate(1);
        comparar("cheio_flag", cheio, 1);
        comparar("cheio_ocup", ocup, VAGAS);
        pe = 1; tick(); pe = 0;
        comparar("negado_cheio", neg, 1);
        abriu = 0;
        repeat (5) begin tick(); if (cancela) abriu = 1; end
        comparar("cancela_cheio", abriu, 0);
        comparar("ocup_cheio", ocup, VAGAS);

        // Down to 5 with entry served last, then simultaneous requests.
        repeat (12) ciclo_gate(0);
        ciclo_gate(1);
        comparar("ocup_cinco", ocup, 5);
        pe = 1; ps = 1; tick(); pe = 0; ps = 0;
        tick();
        comparar("simult_saida_primeiro", {ce, cs}, 2'b01);
        se = 1; tick(); se = 0; tick();
        comparar("simult_ocup_meio", ocup, 4);
        espera_cancela(200);
        comparar("simult_entrada_depois", ce, 1);
        si = 1; tick(); si = 0; tick();
        repeat (GUARDA + 4) tick();
        comparar("simult_ocup_final", ocup, 5);

        // Timeout: granted entry with no vehicle.
        pe = 1; tick(); pe = 0; tick();
        comparar("tout_aberta", cancela, 1);
        n = 0; viu_erro = 0;
        while (cancela === 1'b1 && n < N_TOUT + 100) begin
            tick(); n++;
            if (erro) viu_erro = 1;
        end
        comparar("tout_ciclos", n, N_TOUT);
        comparar("tout_erro", viu_erro, 1);
        comparar("tout_ocup", ocup, 5);
        repeat (GUARDA + 4) tick();

        // Vehicle parked on the loop: never close, never time out.
        pe = 1; tick(); pe = 0; tick();
        si = 1;
        fechou = 0; viu_erro = 0;
        repeat (20000) begin
            tick();
            if (!cancela) fechou = 1;
            if (erro) viu_erro = 1;
        end
        comparar("passando_aberta", fechou, 0);
        comparar("passando_sem_erro", viu_erro, 0);

        // Pending entry, then reset in the middle of the passage.
        pe = 1; tick(); pe = 0;
        rst = 1; tick();
        comparar("rst_meio", {cancela, ce, cs, neg, erro, cheio, vazio, ocup}, 12'b0000001_00000);
        rst = 0; si = 0;
        abriu = 0;
        repeat (5) begin tick(); if (cancela) abriu = 1; end
        comparar("rst_pendente", abriu, 0);

        // Random traffic.
        for (int k = 0; k < 4000; k++) begin
            pe  = ($urandom_range(0, 9) == 0);
            ps  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 4) == 0) se = ~se;
            if ($urandom_range(0, 4) == 0) si = ~si;
            rst = ($urandom_range(0, 1499) == 0);
            tick();
        end
        rst = 0; pe = 0; ps = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
        $finish;
    end

endmodule
